// File: rtl/cfg_logic_tile.sv
// cfg_logic_tile: K-input LUT tile whose truth table, bypass select and flop init
// arrive through a daisy-chained serial shift register.
module cfg_logic_tile #(
  parameter int LUT_K = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic             cfg_in,
  output logic             cfg_out,
  output logic             cfg_done,
  output logic             cfg_err,
  input  logic             ce,
  input  logic [LUT_K-1:0] in,
  output logic             out
);
  localparam int N = 2**LUT_K;
  localparam int CFG_W = N + 2;
  localparam int CW = $clog2(CFG_W + 1);
  typedef enum logic [1:0] {UNCFG, LOAD, ACTIVE} state_t;
  state_t state;
  logic [CFG_W-1:0] cfg_mem;
  logic [N-1:0] lut;
  logic [CW-1:0] bit_cnt;
  logic q;
  logic lut_d;
  logic full;
  assign lut = cfg_mem[N-1:0];
  assign lut_d = lut[in];
  assign full = bit_cnt == CW'(CFG_W);
  assign cfg_out = cfg_mem[0];
  assign cfg_done = state == ACTIVE;
  assign out = (state == ACTIVE) & (cfg_mem[N] ? q : lut_d);
  // The chain shifts on cfg_en in every state so extra bits flow on to the next tile.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= UNCFG;
      cfg_mem <= '0;
      bit_cnt <= '0;
      q <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_en) cfg_mem <= {cfg_in, cfg_mem[CFG_W-1:1]};
      case (state)
        UNCFG: if (cfg_en) begin
          state <= LOAD;
          bit_cnt <= CW'(1);
        end
        LOAD: if (cfg_en) begin
          bit_cnt <= full ? bit_cnt : bit_cnt + CW'(1);
        end else if (full) begin
          state <= ACTIVE;
          q <= cfg_mem[N+1];
        end else begin
          state <= UNCFG;
          cfg_err <= 1'b1;
          bit_cnt <= '0;
        end
        ACTIVE: if (cfg_en) begin
          state <= LOAD;
          bit_cnt <= CW'(1);
        end else if (ce) begin
          q <= lut_d;
        end
        default: state <= UNCFG;
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_logic_tile.sv
// tb_cfg_logic_tile: two chained 3-input tiles checked against a queue of expected outputs.
module tb_cfg_logic_tile;
  localparam int K = 3;
  localparam logic [7:0] M_ERR = 8'h01, M_DONE = 8'h02, M_CO = 8'h04, M_OUT = 8'h08;
  localparam logic [7:0] M_T1ERR = 8'h20, M_T1DONE = 8'h40, M_T1OUT = 8'h80;
  localparam logic [9:0] W2 = 10'b00_0000_0100, W3 = 10'b11_1000_0000;
  localparam logic [9:0] W5A = 10'b00_1010_0110, W5B = 10'b00_0101_1001;
  typedef struct {
    string tag;
    logic [7:0] mask;
    logic [7:0] exp;
  } exp_t;
  logic clock = 0, reset = 1, cfg_en = 0, cfg_in = 0, ce = 0;
  logic [K-1:0] in = '0;
  logic cfg_out0, done0, err0, out0, cfg_out1, done1, err1, out1;
  logic [7:0] obs;
  logic [19:0] sent;
  logic [9:0] wa, wb;
  exp_t sb[$];
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  assign obs = {out1, done1, err1, cfg_out1, out0, cfg_out0, done0, err0};
  cfg_logic_tile #(.LUT_K(K)) t0 (
    .clock(clock), .reset(reset), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out0),
    .cfg_done(done0), .cfg_err(err0), .ce(ce), .in(in), .out(out0)
  );
  cfg_logic_tile #(.LUT_K(K)) t1 (
    .clock(clock), .reset(reset), .cfg_en(cfg_en), .cfg_in(cfg_out0), .cfg_out(cfg_out1),
    .cfg_done(done1), .cfg_err(err1), .ce(ce), .in(in), .out(out1)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [7:0] mask, input logic [7:0] exp);
    sb.push_back('{tag, mask, exp & mask});
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic settle();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs & e.mask, e.exp);
    end
  endtask
  task automatic shift(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en = 1;
      cfg_in = w[i];
      tick();
      push("load_out_done", M_OUT | M_DONE, 8'h00);
      settle();
    end
    cfg_en = 0;
  endtask
  initial begin
    wa = W5A;
    wb = W5B;
    sent = {W5B, W5A};
    // reset held two cycles with ce and in toggling
    for (int c = 0; c < 2; c++) begin
      ce = c[0];
      in = K'($urandom);
      tick();
      push("reset_t0", M_OUT | M_CO | M_DONE | M_ERR, 8'h00);
      push("reset_t1", M_T1OUT | M_T1DONE | M_T1ERR, 8'h00);
      settle();
    end
    reset = 0;
    ce = 0;
    // single-minterm table, LUT path
    shift(W2, 10);
    push("pre_done", M_DONE, 8'h00);
    settle();
    tick();
    push("w2_done", M_DONE | M_ERR, M_DONE);
    settle();
    for (int i = 0; i < 8; i++) begin
      in = K'(i);
      #1;
      push($sformatf("w2_lut_in%0d", i), M_OUT, (i == 2) ? M_OUT : 8'h00);
      settle();
    end
    // registered path with init=1
    shift(W3, 10);
    tick();
    push("w3_init", M_OUT | M_DONE, M_OUT | M_DONE);
    settle();
    in = 0;
    ce = 1;
    tick();
    push("w3_ce_in0", M_OUT, 8'h00);
    settle();
    in = 7;
    ce = 0;
    tick();
    push("w3_hold", M_OUT, 8'h00);
    settle();
    ce = 1;
    tick();
    push("w3_ce_in7", M_OUT, M_OUT);
    settle();
    ce = 0;
    // short load sets sticky error
    reset = 1;
    tick();
    reset = 0;
    shift(W2, 7);
    tick();
    push("short_err", M_OUT | M_DONE | M_ERR, M_ERR);
    settle();
    shift(W2, 10);
    in = 2;
    tick();
    push("reload_err_sticky", M_OUT | M_DONE | M_ERR, M_OUT | M_DONE | M_ERR);
    settle();
    reset = 1;
    tick();
    push("err_cleared", M_OUT | M_CO | M_DONE | M_ERR, 8'h00);
    settle();
    reset = 0;
    // two chained tiles, 20 bits
    for (int k = 1; k <= 20; k++) begin
      cfg_en = 1;
      cfg_in = sent[k-1];
      tick();
      push($sformatf("chain_cfg_out_%0d", k), M_CO, (k >= 10 && sent[k-10]) ? M_CO : 8'h00);
      settle();
    end
    cfg_en = 0;
    tick();
    push("chain_done", M_DONE | M_T1DONE | M_ERR | M_T1ERR, M_DONE | M_T1DONE);
    settle();
    for (int i = 0; i < 8; i++) begin
      in = K'(i);
      #1;
      push($sformatf("chain_lut_in%0d", i), M_OUT | M_T1OUT,
           (wb[i] ? M_OUT : 8'h00) | (wa[i] ? M_T1OUT : 8'h00));
      settle();
    end
    // aborted reconfiguration from ACTIVE
    in = 0;
    #1;
    push("active_before_reconf", M_OUT, M_OUT);
    settle();
    for (int c = 0; c < 4; c++) begin
      cfg_en = 1;
      cfg_in = 1;
      tick();
      push($sformatf("reconf_out_%0d", c), M_OUT | M_DONE, 8'h00);
      settle();
    end
    cfg_en = 0;
    tick();
    push("reconf_abort", M_OUT | M_DONE | M_ERR, M_ERR);
    settle();
    // reset mid-load discards the partial word
    reset = 1;
    tick();
    reset = 0;
    shift(10'h3FF, 5);
    cfg_en = 1;
    reset = 1;
    tick();
    push("midload_reset", M_OUT | M_CO | M_DONE | M_ERR, 8'h00);
    settle();
    reset = 0;
    cfg_in = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      push($sformatf("midload_mem_%0d", k), M_CO | M_OUT, 8'h00);
      settle();
    end
    cfg_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
